// File: rtl/dec_inst_encoder_if.sv
// Handshake bundle between the micro-op source, the LA32 encoder and the fetch-buffer consumer.
interface dec_inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rj;
  logic [4:0]  in_rk;
  logic [25:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  modport master (
    output in_valid, in_op, in_rd, in_rj, in_rk, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rj, in_rk, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/dec_inst_encoder.sv
// LA32 micro-op to instruction-word encoder with a 2-entry {err, inst} output FIFO.
// Inverse of the decode control logic; illegal op ids become "break 0" flagged with err.
module dec_inst_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  dec_inst_encoder_if.slave bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  function automatic logic [16:0] op_3r(input logic [3:0] idx);
    logic [16:0] code;
    case (idx)
      4'd0:    code = 17'h20;
      4'd1:    code = 17'h22;
      4'd2:    code = 17'h24;
      4'd3:    code = 17'h25;
      4'd4:    code = 17'h28;
      4'd5:    code = 17'h29;
      4'd6:    code = 17'h2a;
      4'd7:    code = 17'h2b;
      4'd8:    code = 17'h2c;
      4'd9:    code = 17'h2d;
      4'd10:   code = 17'h2e;
      4'd11:   code = 17'h2f;
      4'd12:   code = 17'h30;
      4'd13:   code = 17'h38;
      4'd14:   code = 17'h39;
      default: code = 17'h3a;
    endcase
    return code;
  endfunction

  function automatic logic [9:0] op_i12(input logic [5:0] op);
    logic [9:0] code;
    case (op)
      6'd21:   code = 10'h008;
      6'd22:   code = 10'h009;
      6'd23:   code = 10'h00a;
      6'd24:   code = 10'h00d;
      6'd25:   code = 10'h00e;
      6'd26:   code = 10'h00f;
      6'd28:   code = 10'h0a0;
      6'd29:   code = 10'h0a1;
      6'd30:   code = 10'h0a2;
      6'd31:   code = 10'h0a4;
      6'd32:   code = 10'h0a5;
      6'd33:   code = 10'h0a6;
      6'd34:   code = 10'h0a8;
      6'd35:   code = 10'h0a9;
      default: code = 10'h000;
    endcase
    return code;
  endfunction

  // Returns {err, inst}; unused register fields stay zero because each format builds the whole word.
  function automatic logic [32:0] encode(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] rj, input logic [4:0] rk,
                                         input logic [25:0] imm);
    logic [31:0] w;
    logic        err;
    logic [5:0]  br;
    w   = 32'h002a0000;
    err = 1'b0;
    br  = op - 6'd16;
    case (op) inside
      [6'd0:6'd15]:  w = {op_3r(op[3:0]), rk, rj, rd};
      6'd16:         w = {17'h54, imm[14:0]};
      6'd17:         w = {17'h56, imm[14:0]};
      6'd18:         w = {17'h81, imm[4:0], rj, rd};
      6'd19:         w = {17'h89, imm[4:0], rj, rd};
      6'd20:         w = {17'h91, imm[4:0], rj, rd};
      [6'd21:6'd26]: w = {op_i12(op), imm[11:0], rj, rd};
      6'd27:         w = {7'h0a, imm[19:0], rd};
      [6'd28:6'd35]: w = {op_i12(op), imm[11:0], rj, rd};
      6'd36:         w = {6'h14, imm[15:0], imm[25:16]};
      6'd37:         w = {6'h15, imm[15:0], imm[25:16]};
      [6'd38:6'd43]: w = {br, imm[15:0], rj, rd};
      default: begin
        w   = 32'h002a0000;
        err = 1'b1;
      end
    endcase
    return {err, w};
  endfunction

  logic [32:0] enc_p0;
  logic        vld_p0;
  logic        pop;
  logic [32:0] mem_p1 [0:1];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [32:0] head_p1;

  // Stage 0: combinational encode of the offered micro-op
  assign enc_p0 = encode(bus.in_op, bus.in_rd, bus.in_rj, bus.in_rk, bus.in_imm);
  assign vld_p0 = bus.in_valid & bus.in_ready & ~flush;
  assign pop    = bus.out_valid & bus.out_ready & ~flush;

  // in_ready only looks at registered occupancy, so a same-cycle pop never frees a full FIFO.
  assign bus.in_ready = (count < 2'(DEPTH)) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (vld_p0) wr_ptr <= ~wr_ptr;
        if (pop)    rd_ptr <= ~rd_ptr;
        case ({vld_p0, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
      if (vld_p0) begin
        enc_count <= enc_count + CNT_W'(1);
        if (enc_p0[32]) err_count <= err_count + CNT_W'(1);
      end
    end
  end

  // Stage 1: FIFO storage; data is unreset and masked by out_valid at the head
  always_ff @(posedge clk) begin
    if (vld_p0) mem_p1[wr_ptr] <= enc_p0;
  end

  assign head_p1       = mem_p1[rd_ptr];
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_inst  = bus.out_valid ? head_p1[31:0] : 32'h0;
  assign bus.out_err   = bus.out_valid & head_p1[32];

endmodule

// File: tb/tb_dec_inst_encoder.sv
// Directed bench for dec_inst_encoder: reference encoder + queue model compared every cycle, plus literal words.
module tb_dec_inst_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] enc_count;
  logic [31:0] err_count;
  int          checks = 0;
  int          errors = 0;

  dec_inst_encoder_if bus();

  dec_inst_encoder #(.DEPTH(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [32:0] q[$];
  logic [31:0] m_enc = 0;
  logic [31:0] m_err = 0;
  bit          started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from opcode tables and positional arithmetic.
  function automatic logic [32:0] ref_enc(input int unsigned op, input int unsigned rd,
                                          input int unsigned rj, input int unsigned rk,
                                          input int unsigned imm);
    int unsigned r3[16];
    int unsigned sh[3];
    int unsigned ia[6];
    int unsigned mm[8];
    int unsigned w;
    r3 = '{'h20, 'h22, 'h24, 'h25, 'h28, 'h29, 'h2a, 'h2b,
           'h2c, 'h2d, 'h2e, 'h2f, 'h30, 'h38, 'h39, 'h3a};
    sh = '{'h81, 'h89, 'h91};
    ia = '{'h008, 'h009, 'h00a, 'h00d, 'h00e, 'h00f};
    mm = '{'h0a0, 'h0a1, 'h0a2, 'h0a4, 'h0a5, 'h0a6, 'h0a8, 'h0a9};
    if (op < 16)       w = r3[op] * 32768 + rk * 1024 + rj * 32 + rd;
    else if (op < 18)  w = (op == 16 ? 'h54 : 'h56) * 32768 + imm % 32768;
    else if (op < 21)  w = sh[op - 18] * 32768 + (imm % 32) * 1024 + rj * 32 + rd;
    else if (op < 27)  w = ia[op - 21] * 4194304 + (imm % 4096) * 1024 + rj * 32 + rd;
    else if (op == 27) w = 'h0a * 33554432 + (imm % 1048576) * 32 + rd;
    else if (op < 36)  w = mm[op - 28] * 4194304 + (imm % 4096) * 1024 + rj * 32 + rd;
    else if (op < 38)  w = ('h14 + op - 36) * 67108864 + (imm % 65536) * 1024 + (imm / 65536) % 1024;
    else if (op < 44)  w = ('h16 + op - 38) * 67108864 + (imm % 65536) * 1024 + rj * 32 + rd;
    else return {1'b1, 32'h002a0000};
    return {1'b0, w};
  endfunction

  // Model: advances on each rising edge from the inputs held stable across it.
  initial forever begin
    bit          pu;
    bit          po;
    logic [32:0] e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_enc = 0;
      m_err = 0;
      started = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      po = (q.size() != 0) && bus.out_ready;
      pu = bus.in_valid && (q.size() < 2);
      e  = ref_enc(bus.in_op, bus.in_rd, bus.in_rj, bus.in_rk, bus.in_imm);
      if (po) void'(q.pop_front());
      if (pu) begin
        q.push_back(e);
        m_enc = m_enc + 1;
        if (e[32]) m_err = m_err + 1;
      end
    end
  end

  // Compare: outputs against the model on every falling edge once reset has been seen.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("in_ready", bus.in_ready, (q.size() < 2) && !rst);
      chk("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_inst", bus.out_inst, q[0][31:0]);
        chk("out_err", bus.out_err, q[0][32]);
      end
      chk("enc_count", enc_count, m_enc);
      chk("err_count", err_count, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input int unsigned op, input int unsigned rd, input int unsigned rj,
                         input int unsigned rk, input int unsigned imm);
    bit acc;
    int n;
    bus.in_op    = 6'(op);
    bus.in_rd    = 5'(rd);
    bus.in_rj    = 5'(rj);
    bus.in_rk    = 5'(rk);
    bus.in_imm   = 26'(imm);
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      acc = bus.in_ready;
      step();
      n++;
      if (n > 2) bus.out_ready = 1'b1;
    end while (!acc && n < 20);
    if (!acc) chk("push_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic push_chk(input string name, input int unsigned op, input int unsigned rd,
                          input int unsigned rj, input int unsigned rk, input int unsigned imm,
                          input logic [31:0] exp);
    push_op(op, rd, rj, rk, imm);
    chk({name, "_valid"}, bus.out_valid, 1);
    chk(name, bus.out_inst, exp);
    chk({name, "_err"}, bus.out_err, 0);
  endtask

  initial begin
    logic [31:0] saved;
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    bus.in_valid = 0; bus.in_op = 0; bus.in_rd = 0; bus.in_rj = 0; bus.in_rk = 0;
    bus.in_imm = 0; bus.out_ready = 0;
    repeat (3) step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_inst", bus.out_inst, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_enc_count", enc_count, 0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", bus.in_ready, 1);

    bus.out_ready = 1'b1;
    push_chk("add_w", 0, 1, 2, 3, 0, 32'h00100c41);
    chk("enc_count_1", enc_count, 1);
    push_chk("addi_w", 23, 4, 5, 0, 'hfff, 32'h02bffca4);
    push_chk("lu12i_w", 27, 1, 0, 0, 'h12345, 32'h142468a1);
    push_chk("b", 36, 0, 0, 0, 'h3ffffff, 32'h53ffffff);
    push_chk("beq", 38, 2, 1, 0, 'h4, 32'h58001022);
    push_chk("slli_w", 18, 3, 4, 0, 5, 32'h00409483);
    push_chk("ori", 25, 6, 7, 0, 'h123, 32'h03848ce6);
    push_chk("st_w", 33, 2, 3, 0, 'h800, 32'h29a00062);
    push_chk("syscall", 17, 0, 0, 0, 5, 32'h002b0005);
    push_chk("bl", 37, 0, 0, 0, 1, 32'h54000400);

    push_op(50, 9, 9, 9, 'h1234);
    chk("illegal_inst", bus.out_inst, 32'h002a0000);
    chk("illegal_err", bus.out_err, 1);
    chk("err_count_1", err_count, 1);

    step();
    bus.out_ready = 1'b0;
    push_op(1, 1, 1, 1, 0);
    push_op(7, 31, 0, 0, 0);
    chk("full_in_ready", bus.in_ready, 0);
    bus.in_op = 6'd16; bus.in_imm = 26'h1234; bus.in_valid = 1'b1;
    repeat (2) begin
      step();
      chk("held_in_ready", bus.in_ready, 0);
      chk("held_head", bus.out_inst, 32'h00110421);
    end
    bus.out_ready = 1'b1;
    step();
    chk("drain_head_y", bus.out_inst, 32'h0015801f);
    step();
    bus.in_valid = 1'b0;
    chk("drain_head_z", bus.out_inst, 32'h002a1234);
    step();
    chk("drained", bus.out_valid, 0);

    for (int op = 0; op < 64; op++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      push_op(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom & 32'h03ffffff);
    end

    bus.out_ready = 1'b1;
    repeat (3) step();
    bus.out_ready = 1'b0;
    push_op(2, 1, 2, 3, 0);
    push_op(3, 4, 5, 6, 0);
    saved = m_enc;
    bus.in_op = 6'd4; bus.in_valid = 1'b1; bus.out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_enc_count", enc_count, saved);

    push_op(5, 1, 1, 1, 0);
    push_op(44, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk("rst2_out_valid", bus.out_valid, 0);
    chk("rst2_out_inst", bus.out_inst, 0);
    chk("rst2_out_err", bus.out_err, 0);
    chk("rst2_enc_count", enc_count, 0);
    chk("rst2_err_count", err_count, 0);
    chk("rst2_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", bus.in_ready, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
